multicycle_core: RTL and testbench
==================================

// Module: multicycle_core
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle datapath. One shared ALU is sequenced by a Moore FSM.
//  Instruction and data memories sit outside the core, each behind a req/ready handshake, so wait-states are tolerated.
//  Adds beq, halt, illegal-opcode flagging and a synchronous reset to the existing lw/sw/addi/R-format set.
// PARAMETERS
//  XLEN     32  datapath and register width
//  PC_W     8   byte-address PC width; imem word address = pc[PC_W-1:2]
//  DADDR_W  8   data-memory word-address width; dmem_addr = alu_result[DADDR_W-1:0]
//  REG_INIT 1   1: reset loads r[i]=i; 0: reset loads r[i]=0 (r0 always reads 0)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous active-low reset
//  imem_req    out  1        instruction fetch request
//  imem_addr   out  PC_W-2   instruction word address
//  imem_rdata  in   32       instruction word, valid when imem_ready=1
//  imem_ready  in   1        fetch complete this cycle
//  dmem_req    out  1        data access request
//  dmem_we     out  1        1=store, 0=load; valid only with dmem_req
//  dmem_addr   out  DADDR_W  data word address
//  dmem_wdata  out  XLEN     store data (rt)
//  dmem_rdata  in   XLEN     load data, valid when dmem_ready=1
//  dmem_ready  in   1        data access complete this cycle
//  pc_out      out  PC_W     current PC
//  state_out   out  3        FSM state encoding, for debug
//  zero        out  1        registered: last ALU result == 0
//  illegal     out  1        one-cycle pulse on an undefined opcode
//  halted      out  1        high while in HALT
// BEHAVIOUR
//  Reset (rst_n low at clk edge):
//   - state=RESET, pc=0, IR=0, zero=0, illegal=0, halted=0, all req=0.
//   - Register file loaded per REG_INIT.
//   - Reset aborts any outstanding handshake: req is low on the following cycle.
//  States: RESET(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) HALT(6).
//   - RESET->FETCH unconditionally once rst_n=1.
//  FETCH: imem_req=1, imem_addr=pc[PC_W-1:2], both held stable until imem_ready.
//   - On the ready edge: IR<=imem_rdata, pc<=pc+4 (wraps mod 2^PC_W), ->DECODE.
//  DECODE: A<=r[rs], B<=r[rt], imm<=sext(IR[15:0]). Next state by opcode IR[31:26]:
//   - 000000 R, 100011 lw, 101011 sw, 001000 addi, 000100 beq: ->EXEC.
//   - 111111 halt: ->HALT.
//   - Any other opcode: illegal pulses 1 cycle, no architectural change, ->FETCH.
//  EXEC: ALU computes; zero<=(result==0); ALUOut<=result.
//   - R-format decodes funct[3:0]; funct[5:4] ignored:
//     0000 add, 0010 sub, 0100 and, 0101 or, 0111 nor, 0110 nand, 1010 slt (signed, result 1/0).
//   - Other funct: result 0, rd still written.
//   - lw/sw/addi: A+imm. beq: A-B; if zero, pc<=pc+(imm<<2) (pc already +4), mod 2^PC_W.
//   - Next: R/addi->WB, lw/sw->MEM, beq->FETCH.
//  MEM: dmem_req=1, dmem_we=(sw), dmem_addr=ALUOut[DADDR_W-1:0], dmem_wdata=B, all held until dmem_ready.
//   - lw: MDR<=dmem_rdata on the ready edge, ->WB. sw: ->FETCH on the ready edge.
//  WB: R writes r[rd]<=ALUOut; addi writes r[rt]<=ALUOut; lw writes r[rt]<=MDR.
//   - Writes to r0 are discarded. ->FETCH.
//  HALT: halted=1; no requests issued; exited only by reset.
//  Arithmetic wraps mod 2^XLEN; no overflow trap.
//  Latency with zero wait-states: R/addi 4, lw 5, sw 4, beq 3 cycles; each wait-state adds 1.
//  ready while req=0 is ignored. Register reads in DECODE see WB writes of the prior instruction.
// TESTING
//  1. Reset, REG_INIT=1, add r3,r1,r2 at 0 (imem_ready always 1) -> r3=3 after 4 cycles, pc_out=4.
//  2. lw r5,4(r0) with dmem_ready delayed 3 cycles, mem[4]=0xDEADBEEF -> dmem_req/addr stable 4 cycles; r5=0xDEADBEEF, total 8 cycles.
//  3. beq r1,r1,-1 at pc=8 -> pc returns to 8 every 3 cycles; beq r1,r2,-1 -> pc=12.
//  4. slt r4,r7,r6 with r7=0xFFFFFFFF, r6=1 -> r4=1 (signed compare); sub giving 0 -> zero=1.
//  5. Opcode 010101 -> illegal pulses once, no register or memory change; halt opcode -> halted=1, no further imem_req.
//  6. rst_n low mid-MEM with dmem_ready=0 -> next cycle dmem_req=0, pc_out=0, regs reinitialised; fetch restarts at 0.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Memory-side bus of the multi-cycle core: instruction fetch port and data
// access port, each a req/ready handshake.
interface multicycle_core_if #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
);
  logic               imem_req;
  logic [PC_W-3:0]    imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ready;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]    dmem_wdata;
  logic [XLEN-1:0]    dmem_rdata;
  logic               dmem_ready;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-like core: one shared ALU sequenced by a Moore FSM,
// external instruction/data memories behind req/ready handshakes.
module multicycle_core #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 8,
  parameter int DADDR_W  = 8,
  parameter int REG_INIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_core_if.master bus,
  output logic [PC_W-1:0]  pc_out,
  output logic [2:0]       state_out,
  output logic             zero,
  output logic             illegal,
  output logic             halted
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_out, mdr;
  logic [XLEN-1:0] alu_res;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [5:0] funct;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];

  // Shared ALU: R-format by funct[3:0], beq compares by subtraction,
  // everything else (lw/sw/addi) forms base + immediate.
  always_comb begin
    alu_res = '0;
    if (op == OP_R) begin
      case (funct[3:0])
        4'b0000: alu_res = a_q + b_q;
        4'b0010: alu_res = a_q - b_q;
        4'b0100: alu_res = a_q & b_q;
        4'b0101: alu_res = a_q | b_q;
        4'b0111: alu_res = ~(a_q | b_q);
        4'b0110: alu_res = ~(a_q & b_q);
        4'b1010: alu_res = ($signed(a_q) < $signed(b_q)) ? XLEN'(1) : '0;
        default: alu_res = '0;
      endcase
    end else if (op == OP_BEQ) begin
      alu_res = a_q - b_q;
    end else begin
      alu_res = a_q + imm_q;
    end
  end

  // Sequencer, datapath registers and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RESET;
      pc      <= '0;
      ir      <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      halted  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= (REG_INIT != 0) ? XLEN'(i) : '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            pc    <= pc + PC_W'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rf[rs];
          b_q   <= rf[rt];
          imm_q <= {{(XLEN-16){ir[15]}}, ir[15:0]};
          case (op)
            OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ: state <= S_EXEC;
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              illegal <= 1'b1;
              state   <= S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          zero    <= (alu_res == '0);
          alu_out <= alu_res;
          case (op)
            OP_BEQ: begin
              // pc already points past the branch, so the offset is relative to pc+4
              if (alu_res == '0) pc <= pc + {imm_q[PC_W-3:0], 2'b00};
              state <= S_FETCH;
            end
            OP_LW, OP_SW: state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_LW) begin
              mdr   <= bus.dmem_rdata;
              state <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (op == OP_R) begin
            if (rd != 5'd0) rf[rd] <= alu_out;
          end else if (op == OP_ADDI) begin
            if (rt != 5'd0) rf[rt] <= alu_out;
          end else if (op == OP_LW) begin
            if (rt != 5'd0) rf[rt] <= mdr;
          end
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Bus outputs decode straight from registered state and datapath
  // registers, so they stay stable for the whole of a wait-state run.
  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc[PC_W-1:2];
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = alu_out[DADDR_W-1:0];
  assign bus.dmem_wdata = b_q;
  assign pc_out         = pc;
  assign state_out      = state;

  logic unused_bits;
  assign unused_bits = ^{funct[5:4], imm_q[XLEN-1:PC_W-2]};
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: single-instruction vector table plus
// hand-written multi-cycle sequences (wait-states, branch loops, illegal/halt,
// reset during a data access).
module tb_multicycle_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]  pc_out;
  logic [2:0]  state_out;
  logic        zero, illegal, halted;

  multicycle_core_if bus();

  multicycle_core dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pc_out(pc_out),
    .state_out(state_out), .zero(zero), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory models: combinational read, data side with programmable wait-states.
  logic [31:0] imem [64];
  logic [31:0] dmem [256];
  int dwait = 0;
  int dcnt = 0;
  int st_cnt = 0;
  logic [7:0]  st_addr;
  logic [31:0] st_data;

  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.imem_ready = 1'b1;
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  assign bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);

  always @(posedge clk) begin
    if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (!rst_n) st_cnt <= 0;
    else if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= bus.dmem_addr;
      st_data <= bus.dmem_wdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFC000000;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    int          lat;
    int          rsel;
    logic [31:0] rexp;
    logic [7:0]  pcexp;
    bit          mchk;
    logic [7:0]  maddr;
    logic [31:0] mval;
  } vec_t;

  vec_t vt [16];

  initial begin
    int ic, dc, ia, cnt;
    // r[i]=i after reset; each vector runs alone from pc 0
    vt[0]  = '{32'h00221820, 4, 3, 32'h00000003, 8'd4,  1'b0, 8'd0, 32'd0}; // add r3,r1,r2
    vt[1]  = '{32'h00E22022, 4, 4, 32'h00000005, 8'd4,  1'b0, 8'd0, 32'd0}; // sub r4,r7,r2
    vt[2]  = '{32'h00C32824, 4, 5, 32'h00000002, 8'd4,  1'b0, 8'd0, 32'd0}; // and r5,r6,r3
    vt[3]  = '{32'h00C32825, 4, 5, 32'h00000007, 8'd4,  1'b0, 8'd0, 32'd0}; // or
    vt[4]  = '{32'h00C32827, 4, 5, 32'hFFFFFFF8, 8'd4,  1'b0, 8'd0, 32'd0}; // nor
    vt[5]  = '{32'h00C32826, 4, 5, 32'hFFFFFFFD, 8'd4,  1'b0, 8'd0, 32'd0}; // nand
    vt[6]  = '{32'h0066282A, 4, 5, 32'h00000001, 8'd4,  1'b0, 8'd0, 32'd0}; // slt r5,r3,r6
    vt[7]  = '{32'h00C32821, 4, 5, 32'h00000000, 8'd4,  1'b0, 8'd0, 32'd0}; // undefined funct -> 0
    vt[8]  = '{32'h00C32800, 4, 5, 32'h00000009, 8'd4,  1'b0, 8'd0, 32'd0}; // funct 000000 = add
    vt[9]  = '{32'h2048FFFD, 4, 8, 32'hFFFFFFFF, 8'd4,  1'b0, 8'd0, 32'd0}; // addi r8,r2,-3
    vt[10] = '{32'h00220020, 4, 0, 32'h00000000, 8'd4,  1'b0, 8'd0, 32'd0}; // add r0 discarded
    vt[11] = '{32'h1022FFFF, 3, 1, 32'h00000001, 8'd4,  1'b0, 8'd0, 32'd0}; // beq not taken
    vt[12] = '{32'h10210002, 3, 1, 32'h00000001, 8'd12, 1'b0, 8'd0, 32'd0}; // beq taken +2
    vt[13] = '{32'h1000FFFF, 3, 1, 32'h00000001, 8'd0,  1'b0, 8'd0, 32'd0}; // beq taken -1
    vt[14] = '{32'h8C050004, 5, 5, 32'hDEADBEEF, 8'd4,  1'b0, 8'd0, 32'd0}; // lw r5,4(r0)
    vt[15] = '{32'hAC270002, 4, 7, 32'h00000007, 8'd4,  1'b1, 8'd3, 32'd7}; // sw r7,2(r1)

    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[4] = 32'hDEADBEEF;
    clear_imem();

    // reset state
    do_reset();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_flags", {29'd0, zero, illegal, halted}, 32'd0);
    chk("rst_req", {30'd0, bus.imem_req, bus.dmem_req}, 32'd0);
    chk("rst_r7", dut.rf[7], 32'd7);

    // table-driven single instructions
    for (int v = 0; v < 16; v++) begin
      clear_imem();
      imem[0] = vt[v].instr;
      dwait = 0;
      do_reset();
      step(1 + vt[v].lat);
      chk($sformatf("v%0d_reg", v), dut.rf[vt[v].rsel], vt[v].rexp);
      chk($sformatf("v%0d_pc", v), 32'(pc_out), 32'(vt[v].pcexp));
      chk($sformatf("v%0d_state", v), 32'(state_out), 32'd1);
      if (vt[v].mchk) begin
        chk($sformatf("v%0d_stcnt", v), st_cnt, 32'd1);
        chk($sformatf("v%0d_staddr", v), 32'(st_addr), 32'(vt[v].maddr));
        chk($sformatf("v%0d_stdata", v), st_data, vt[v].mval);
      end
    end

    // lw with three data wait-states: request held 4 cycles, 8 cycles total
    clear_imem();
    imem[0] = 32'h8C050004;
    dwait = 3;
    do_reset();
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (bus.dmem_req && bus.dmem_addr == 8'd4 && !bus.dmem_we) cnt++;
    end
    chk("lw_wait_reqcyc", cnt, 32'd4);
    chk("lw_wait_r5", dut.rf[5], 32'hDEADBEEF);
    chk("lw_wait_state", 32'(state_out), 32'd1);
    dwait = 0;

    // branch loop at pc 8 returns every 3 cycles
    clear_imem();
    imem[0] = 32'h10000001;   // beq r0,r0,+1 -> pc 8
    imem[2] = 32'h1021FFFF;   // beq r1,r1,-1
    do_reset();
    step(4);
    chk("loop_enter_pc", 32'(pc_out), 32'd8);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("loop%0d_mid_pc", k), 32'(pc_out), 32'd12);
      step(2);
      chk($sformatf("loop%0d_pc", k), 32'(pc_out), 32'd8);
    end
    imem[2] = 32'h1022FFFF;   // beq r1,r2,-1 not taken
    do_reset();
    step(7);
    chk("loop_exit_pc", 32'(pc_out), 32'd12);

    // signed slt using a WB value from the prior instruction, then zero flag
    clear_imem();
    imem[0] = 32'h2007FFFF;   // addi r7,r0,-1
    imem[1] = 32'h00E6202A;   // slt r4,r7,r6
    imem[2] = 32'h00214822;   // sub r9,r1,r1
    do_reset();
    step(9);
    chk("slt_r7", dut.rf[7], 32'hFFFFFFFF);
    chk("slt_r4", dut.rf[4], 32'd1);
    chk("slt_zero", 32'(zero), 32'd0);
    step(4);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_r9", dut.rf[9], 32'd0);

    // illegal opcode then halt
    clear_imem();
    imem[0] = 32'h54000000;
    imem[1] = 32'hFC000000;
    do_reset();
    ic = 0; dc = 0; ia = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (illegal) ic++;
      if (bus.dmem_req) dc++;
      if (halted && bus.imem_req) ia++;
    end
    chk("ill_pulses", ic, 32'd1);
    chk("ill_dmem", dc, 32'd0);
    chk("ill_r5", dut.rf[5], 32'd5);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_state", 32'(state_out), 32'd6);
    chk("halt_noreq", ia, 32'd0);
    chk("halt_pc", 32'(pc_out), 32'd8);

    // reset while a load waits in MEM
    clear_imem();
    imem[0] = 32'h2003004D;   // addi r3,r0,77
    imem[1] = 32'h8C050004;   // lw r5,4(r0)
    dwait = 1000;
    do_reset();
    step(8);
    chk("mem_req_held", 32'(bus.dmem_req), 32'd1);
    chk("mem_r3_77", dut.rf[3], 32'd77);
    rst_n = 1'b0;
    step(1);
    chk("abort_dreq", 32'(bus.dmem_req), 32'd0);
    chk("abort_pc", 32'(pc_out), 32'd0);
    chk("abort_r3", dut.rf[3], 32'd3);
    chk("abort_state", 32'(state_out), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("restart_ireq", 32'(bus.imem_req), 32'd1);
    chk("restart_iaddr", 32'(bus.imem_addr), 32'd0);
    dwait = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
